// File: rtl/cpu_mem_responder.sv
// Single-ported word memory that serves a CPU's instruction and data ports one
// transaction at a time, with a fixed response latency and alternating tie-break.
module cpu_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mbe,
  output logic [31:0] data_rdata,
  output logic        data_resp
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        last_data, last_data_next;
  logic        grant_data, grant_data_next;
  logic [31:0] cap, cap_next;
  logic        inst_resp_next, data_resp_next;
  logic [31:0] inst_rdata_next, data_rdata_next;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] inst_idx, data_idx, sel_idx;
  logic          data_req, pick_data, do_write;
  logic [31:0]   rd_word;
  logic          unused_addr_bits;

  assign inst_idx  = inst_addr[AW+1:2];
  assign data_idx  = data_addr[AW+1:2];
  assign data_req  = data_read | data_write;
  // On a tie the port that did not win last time is served.
  assign pick_data = data_req & (~inst_read | ~last_data);
  assign sel_idx   = pick_data ? data_idx : inst_idx;
  assign rd_word   = mem[sel_idx];
  assign unused_addr_bits = ^{inst_addr[31:AW+2], inst_addr[1:0],
                              data_addr[31:AW+2], data_addr[1:0]};

  // Next-state, grant and response decode.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_data_next  = last_data;
    grant_data_next = grant_data;
    cap_next        = cap;
    inst_resp_next  = 1'b0;
    data_resp_next  = 1'b0;
    inst_rdata_next = inst_rdata;
    data_rdata_next = data_rdata;
    do_write        = 1'b0;
    case (state)
      IDLE: begin
        if (inst_read || data_req) begin
          state_next      = BUSY;
          cnt_next        = LAT_M1;
          last_data_next  = pick_data;
          grant_data_next = pick_data;
          cap_next        = rd_word;
          do_write        = pick_data & data_write;
          // Responses are registered, so they are scheduled one edge ahead.
          if (LATENCY == 1) begin
            if (pick_data) begin
              data_resp_next  = 1'b1;
              data_rdata_next = rd_word;
            end else begin
              inst_resp_next  = 1'b1;
              inst_rdata_next = rd_word;
            end
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
        if (cnt == 4'd1) begin
          if (grant_data) begin
            data_resp_next  = 1'b1;
            data_rdata_next = cap;
          end else begin
            inst_resp_next  = 1'b1;
            inst_rdata_next = cap;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_data  <= 1'b0;
      grant_data <= 1'b0;
      cap        <= 32'd0;
      inst_resp  <= 1'b0;
      data_resp  <= 1'b0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      last_data  <= last_data_next;
      grant_data <= grant_data_next;
      cap        <= cap_next;
      inst_resp  <= inst_resp_next;
      data_resp  <= data_resp_next;
      inst_rdata <= inst_rdata_next;
      data_rdata <= data_rdata_next;
    end
  end

  // Byte-masked store; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_write && data_mbe[i]) begin
        mem[data_idx][8*i +: 8] <= data_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench: drivers queue expected responses, monitors check port,
// cycle and word whenever a DUT raises a resp.
module tb_cpu_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    bit          is_data;
    bit          check;
    logic [31:0] word;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic        inst_read, data_read, data_write, inst_resp, data_resp;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_mbe;

  logic        i1_read, d1_read, d1_write, i1_resp, d1_resp;
  logic [31:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata;
  logic [3:0]  d1_mbe;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [31:0] inst_model, data_model;
  bit          inst_known, data_known;
  logic [31:0] s_addr [4];
  logic [31:0] s_word [4];

  cpu_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_resp(inst_resp),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_mbe(data_mbe), .data_rdata(data_rdata), .data_resp(data_resp)
  );

  cpu_mem_responder #(.DEPTH_WORDS(16), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_read(i1_read), .inst_addr(i1_addr), .inst_rdata(i1_rdata), .inst_resp(i1_resp),
    .data_read(d1_read), .data_write(d1_write), .data_addr(d1_addr),
    .data_wdata(d1_wdata), .data_mbe(d1_mbe), .data_rdata(d1_rdata), .data_resp(d1_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  // Scoreboard for the LATENCY=2 instance, including hold of the idle port's rdata.
  always @(negedge clk) begin
    if (!rst && (inst_resp || data_resp)) begin
      if (inst_resp && data_resp) chk("resp_overlap", 32'(inst_resp & data_resp), 32'd0);
      if (q0.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got resp at cycle %0d, required none", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("resp_port", 32'(data_resp), 32'(e0.is_data));
        chk("resp_cycle", 32'(cyc), 32'(e0.cyc));
        if (e0.is_data) begin
          if (e0.check) chk("data_rdata", data_rdata, e0.word);
          if (inst_known) chk("inst_rdata_hold", inst_rdata, inst_model);
          data_known = e0.check;
          data_model = e0.word;
        end else begin
          if (e0.check) chk("inst_rdata", inst_rdata, e0.word);
          if (data_known) chk("data_rdata_hold", data_rdata, data_model);
          inst_known = e0.check;
          inst_model = e0.word;
        end
      end
    end
  end

  // Scoreboard for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (!rst && (i1_resp || d1_resp)) begin
      if (i1_resp && d1_resp) chk("resp_overlap1", 32'(i1_resp & d1_resp), 32'd0);
      if (q1.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp1: got resp at cycle %0d, required none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("resp_port1", 32'(d1_resp), 32'(e1.is_data));
        chk("resp_cycle1", 32'(cyc), 32'(e1.cyc));
        if (e1.check) chk("rdata1", e1.is_data ? d1_rdata : i1_rdata, e1.word);
      end
    end
  end

  task automatic dtxn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mbe, input bit ck, input logic [31:0] exp, input bit drop);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    data_read = rd; data_write = wr; data_addr = addr; data_wdata = wdata; data_mbe = mbe;
    q0.push_back('{1'b1, ck, exp, cyc + LAT0});
    if (drop) begin
      @(posedge clk); #1;
      data_read = 1'b0; data_write = 1'b0;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = data_resp;
    end
    data_read = 1'b0; data_write = 1'b0;
    if (!got) begin total++; $display("FAIL data_timeout: got no data_resp, required one within 40 cycles"); end
  endtask

  task automatic itxn(input logic [31:0] addr, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    inst_read = 1'b1; inst_addr = addr;
    q0.push_back('{1'b0, 1'b1, exp, cyc + LAT0});
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = inst_resp;
    end
    inst_read = 1'b0;
    if (!got) begin total++; $display("FAIL inst_timeout: got no inst_resp, required one within 40 cycles"); end
  endtask

  task automatic tie(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] iw,
                     input logic [31:0] dw, input bit data_first);
    bit ig, dg;
    ig = 1'b0; dg = 1'b0;
    @(posedge clk); #1;
    inst_read = 1'b1; inst_addr = ia; data_read = 1'b1; data_addr = da;
    // Loser is accepted in the IDLE cycle after the winner's resp.
    if (data_first) begin
      q0.push_back('{1'b1, 1'b1, dw, cyc + LAT0});
      q0.push_back('{1'b0, 1'b1, iw, cyc + 2*LAT0 + 1});
    end else begin
      q0.push_back('{1'b0, 1'b1, iw, cyc + LAT0});
      q0.push_back('{1'b1, 1'b1, dw, cyc + 2*LAT0 + 1});
    end
    for (int i = 0; i < 40 && !(ig && dg); i++) begin
      @(negedge clk);
      if (data_resp) begin data_read = 1'b0; dg = 1'b1; end
      if (inst_resp) begin inst_read = 1'b0; ig = 1'b1; end
    end
    inst_read = 1'b0; data_read = 1'b0;
    if (!(ig && dg)) begin total++; $display("FAIL tie_timeout: got inst=%0d data=%0d, required both", ig, dg); end
  endtask

  task automatic abort_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    data_read = !wr; data_write = wr; data_addr = addr; data_wdata = wdata; data_mbe = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; data_read = 1'b0; data_write = 1'b0;
    #1;
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_resps", 32'({inst_resp, data_resp}), 32'd0);
    inst_model = 32'd0; data_model = 32'd0; inst_known = 1'b1; data_known = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    inst_read = 1'b0; inst_addr = 32'd0; data_read = 1'b0; data_write = 1'b0;
    data_addr = 32'd0; data_wdata = 32'd0; data_mbe = 4'h0;
    i1_read = 1'b0; i1_addr = 32'd0; d1_read = 1'b0; d1_write = 1'b0;
    d1_addr = 32'd0; d1_wdata = 32'd0; d1_mbe = 4'h0;
    inst_model = 32'd0; data_model = 32'd0; inst_known = 1'b1; data_known = 1'b1;
    #2;
    chk("reset_inst_rdata", inst_rdata, 32'd0);
    chk("reset_data_rdata", data_rdata, 32'd0);
    chk("reset_resps", 32'({inst_resp, data_resp, i1_resp, d1_resp}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    dtxn(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, 1'b0);
    dtxn(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    dtxn(1'b0, 1'b1, 32'h104, 32'h11223344, 4'hF, 1'b0, 32'd0, 1'b0);
    // Lanes 0 and 2 take new bytes; the store returns the old word.
    dtxn(1'b0, 1'b1, 32'h104, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h11223344, 1'b0);
    dtxn(1'b1, 1'b0, 32'h104, 32'd0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0);
    dtxn(1'b1, 1'b1, 32'h100, 32'h01020304, 4'b1000, 1'b1, 32'hDEADBEEF, 1'b0);
    dtxn(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b1, 32'h01ADBEEF, 1'b1);
    dtxn(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, 1'b0);
    itxn(32'h0000, 32'hCAFEF00D);
    tie(32'h100, 32'h104, 32'h01ADBEEF, 32'h11BB33DD, 1'b1);
    dtxn(1'b1, 1'b0, 32'h0, 32'd0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    tie(32'h104, 32'h100, 32'h11BB33DD, 32'h01ADBEEF, 1'b0);
    abort_txn(1'b0, 32'h104, 32'd0);
    abort_txn(1'b1, 32'h100, 32'h99999999);
    dtxn(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b1, 32'h99999999, 1'b0);
    itxn(32'h104, 32'h11BB33DD);
    itxn(32'hFFFF_F102, 32'h99999999);

    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      @(posedge clk); #1;
      d1_write = 1'b1; d1_addr = 32'(i * 4); d1_wdata = 32'hA000_0000 + 32'(i); d1_mbe = 4'hF;
      q1.push_back('{1'b1, 1'b0, 32'd0, cyc + LAT1});
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        got = d1_resp;
      end
      d1_write = 1'b0;
      if (!got) begin total++; $display("FAIL d1_timeout: got no data_resp, required one"); end
    end
    s_addr[0] = 32'h0; s_addr[1] = 32'h4; s_addr[2] = 32'h8; s_addr[3] = 32'h40;
    s_word[0] = 32'hA0000000; s_word[1] = 32'hA0000001;
    s_word[2] = 32'hA0000002; s_word[3] = 32'hA0000000;
    @(posedge clk); #1;
    i1_read = 1'b1; i1_addr = s_addr[0];
    for (int j = 0; j < 4; j++) q1.push_back('{1'b0, 1'b1, s_word[j], cyc + LAT1 + 2*j});
    for (int j = 0; j < 4; j++) begin
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        got = i1_resp;
      end
      if (!got) begin total++; $display("FAIL i1_timeout: got no inst_resp, required one"); end
      if (j < 3) i1_addr = s_addr[j+1];
    end
    i1_read = 1'b0;

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
